// File: rtl/skew_buffer.sv
// skew_buffer: per-lane delay line, lane k delays by De + k*SKEW enable events (De = clamped dly).
// Latency: L_k en events; outputs registered, en-to-output one clock edge; no input-to-output comb path.
// No backpressure: en low freezes every lane. Define SKEW_BUFFER_VLD_EN to store and delay the valid sideband.
module skew_buffer #(
  parameter int LANES = 8,
  parameter int BITS  = 8,
  parameter int DEPTH = 8,
  parameter int SKEW  = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_en,
  input  logic [$clog2(DEPTH+1)-1:0] i_dly,
  input  logic [LANES*BITS-1:0]      i_d,
  input  logic [LANES-1:0]           i_vld_in,
  output logic [LANES*BITS-1:0]      o_q,
  output logic [LANES-1:0]           o_vld_out,
  output logic                       o_primed
);

  localparam int CMAX = DEPTH + (LANES-1)*SKEW;
  localparam int CW   = $clog2(CMAX+1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_de;
  logic          r_primed;

  // Clamp the requested base delay into 1..DEPTH.
  always_comb begin
    w_de = CW'(i_dly);
    if (i_dly == '0) begin
      w_de = CW'(1);
    end else if (CW'(i_dly) > CW'(DEPTH)) begin
      w_de = CW'(DEPTH);
    end
  end

  // Fill count after this cycle's en; saturates once the longest lane can be full.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_en && (r_cnt != CW'(CMAX))) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // Fill counter and primed flag; primed follows dly changes even while en is low.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_primed <= (w_cnt_nxt >= (w_de + CW'((LANES-1)*SKEW)));
    end
  end

  assign o_primed = r_primed;

`ifndef SKEW_BUFFER_VLD_EN
  // Valid sideband is not stored in this build.
  logic w_unused_vld;
  assign w_unused_vld = ^i_vld_in;
`endif

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    // Line holds L-1 history entries; the output register supplies the last stage.
    localparam int LMAX = DEPTH + g*SKEW;
    localparam int LEN  = (LMAX > 1) ? (LMAX - 1) : 1;

    logic [BITS-1:0] r_line [LEN];
    logic [BITS-1:0] r_q;
    logic [BITS-1:0] w_tap;
    logic [CW-1:0]   w_lk;
    logic            r_vld;

    assign w_lk = w_de + CW'(g*SKEW);

    // Tap select: latency 1 takes the live input, latency L takes line entry L-2.
    always_comb begin
      w_tap = i_d[g*BITS +: BITS];
      for (int i = 0; i < LEN; i++) begin
        if (w_lk == CW'(i+2)) w_tap = r_line[i];
      end
    end

    // Shift the data line and capture the tap on each en event.
    always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
        for (int i = 0; i < LEN; i++) r_line[i] <= '0;
        r_q <= '0;
      end else if (i_en) begin
        r_line[0] <= i_d[g*BITS +: BITS];
        for (int i = 1; i < LEN; i++) r_line[i] <= r_line[i-1];
        r_q <= w_tap;
      end
    end

`ifdef SKEW_BUFFER_VLD_EN
    logic [LEN-1:0] r_vline;
    logic           w_vtap;

    // Valid tap mirrors the data tap.
    always_comb begin
      w_vtap = i_vld_in[g];
      for (int i = 0; i < LEN; i++) begin
        if (w_lk == CW'(i+2)) w_vtap = r_vline[i];
      end
    end

    // Shift the valid line alongside the data line.
    always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
        r_vline <= '0;
        r_vld   <= 1'b0;
      end else if (i_en) begin
        r_vline[0] <= i_vld_in[g];
        for (int i = 1; i < LEN; i++) r_vline[i] <= r_vline[i-1];
        r_vld <= w_vtap;
      end
    end
`else
    // Without stored valids, a lane is valid once it has filled since reset/clr.
    always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
        r_vld <= 1'b0;
      end else begin
        r_vld <= (w_cnt_nxt >= w_lk);
      end
    end
`endif

    assign o_q[g*BITS +: BITS] = r_q;
    assign o_vld_out[g]        = r_vld;
  end

endmodule

// File: tb/tb_skew_buffer.sv
// tb_skew_buffer: directed and randomized stimulus for skew_buffer (LANES=4, BITS=8, DEPTH=4, SKEW=1).
// Expected outputs come from an input-history model and are queued; a monitor compares each cycle.
// Honours SKEW_BUFFER_VLD_EN the same way the design does.
module tb_skew_buffer;
  localparam int LANES = 4;
  localparam int BITS  = 8;
  localparam int DEPTH = 4;
  localparam int SKEW  = 1;
  localparam int CMAX  = DEPTH + (LANES-1)*SKEW;

  logic        clk = 1'b0;
  logic        rst, clr, en;
  logic [2:0]  dly;
  logic [31:0] d;
  logic [3:0]  vld_in;
  logic [31:0] q;
  logic [3:0]  vld_out;
  logic        primed;

  skew_buffer #(.LANES(LANES), .BITS(BITS), .DEPTH(DEPTH), .SKEW(SKEW)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_en(en), .i_dly(dly),
    .i_d(d), .i_vld_in(vld_in), .o_q(q), .o_vld_out(vld_out), .o_primed(primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  v;
    logic        p;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hd[$];   // data accepted since last reset/clr, oldest first
  logic [3:0]  hv[$];
  logic [31:0] eq = '0;
  logic [3:0]  ev = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic int de(input int x);
    if (x == 0) return 1;
    if (x > DEPTH) return DEPTH;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the model's expectation, wait for the next negedge.
  task automatic step(input logic r, input logic c, input logic e, input logic [2:0] dl,
                      input logic [31:0] dd, input logic [3:0] vv);
    exp_t x;
    int   n, idx, lk, cnt;
    rst = r; clr = c; en = e; dly = dl; d = dd; vld_in = vv;
    if (r || c) begin
      hd.delete(); hv.delete();
      eq = '0; ev = '0;
    end else if (e) begin
      hd.push_back(dd); hv.push_back(vv);
      n = hd.size();
      for (int k = 0; k < LANES; k++) begin
        lk  = de(int'(dl)) + k*SKEW;
        idx = n - lk;
        eq[k*BITS +: BITS] = (idx >= 0) ? hd[idx][k*BITS +: BITS] : 8'h00;
`ifdef SKEW_BUFFER_VLD_EN
        ev[k] = (idx >= 0) ? hv[idx][k] : 1'b0;
`endif
      end
    end
    cnt = (hd.size() > CMAX) ? CMAX : hd.size();
`ifndef SKEW_BUFFER_VLD_EN
    for (int k = 0; k < LANES; k++) ev[k] = !(r || c) && (cnt >= de(int'(dl)) + k*SKEW);
`endif
    x.q = eq;
    x.v = ev;
    x.p = !(r || c) && (cnt >= de(int'(dl)) + (LANES-1)*SKEW);
    sb.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: one expectation per clock, compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("q", q, x.q);
        chk("vld_out", {28'd0, vld_out}, {28'd0, x.v});
        chk("primed", {31'd0, primed}, {31'd0, x.p});
      end
    end
  end

  initial begin
    logic [31:0] nn;
    // Reset with random inputs.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0,1), $urandom_range(0,1), 3'($urandom_range(0,7)), $urandom, 4'($urandom));
    chk("reset_q", q, 32'd0);
    chk("reset_primed", {31'd0, primed}, 32'd0);

    // Skew wavefront, dly=1, d_k = n at event n.
    for (int n = 1; n <= 5; n++) begin
      nn = 32'(n);
      step(1'b0, 1'b0, 1'b1, 3'd1, {4{nn[7:0]}}, 4'hF);
      chk("wave_primed", {31'd0, primed}, (n >= 4) ? 32'd1 : 32'd0);
    end
    chk("wave_q5", q, 32'h02030405);

    // Enable gap: outputs hold.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 3'd1, $urandom, 4'($urandom));
      chk("gap_q", q, 32'h02030405);
      chk("gap_primed", {31'd0, primed}, 32'd1);
    end
    step(1'b0, 1'b0, 1'b1, 3'd1, 32'h06060606, 4'hF);
    chk("resume_q", q, 32'h03040506);

    // Flush with en and 0xAA present.
    step(1'b0, 1'b1, 1'b1, 3'd1, 32'hAAAAAAAA, 4'hF);
    chk("flush_q", q, 32'd0);
    chk("flush_vld", {28'd0, vld_out}, 32'd0);
    chk("flush_primed", {31'd0, primed}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 3'd1, 32'h01010101, 4'hF);
    chk("post_flush_q", q, 32'h00000001);

    // Clamp high: dly=7 behaves as 4, primed after 7 events.
    step(1'b0, 1'b1, 1'b0, 3'd7, 32'd0, 4'h0);
    for (int n = 1; n <= 8; n++) begin
      nn = 32'(n);
      step(1'b0, 1'b0, 1'b1, 3'd7, {4{nn[7:0]}}, 4'hF);
      chk("clamp7_primed", {31'd0, primed}, (n >= 7) ? 32'd1 : 32'd0);
      chk("clamp7_q0", {24'd0, q[7:0]}, (n >= 4) ? 32'(n - 3) : 32'd0);
    end

    // Clamp low: dly=0 behaves as 1, primed after 4 events.
    step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
    for (int n = 1; n <= 5; n++) begin
      nn = 32'(n);
      step(1'b0, 1'b0, 1'b1, 3'd0, {4{nn[7:0]}}, 4'hF);
      chk("clamp0_primed", {31'd0, primed}, (n >= 4) ? 32'd1 : 32'd0);
      chk("clamp0_q0", {24'd0, q[7:0]}, 32'(n));
    end

    // Single valid pulse, dly=2.
    step(1'b0, 1'b1, 1'b0, 3'd2, 32'd0, 4'h0);
    for (int n = 1; n <= 7; n++) begin
      step(1'b0, 1'b0, 1'b1, 3'd2, $urandom, (n == 1) ? 4'hF : 4'h0);
`ifdef SKEW_BUFFER_VLD_EN
      for (int k = 0; k < LANES; k++)
        chk("vld_pulse", {31'd0, vld_out[k]}, (n == 2 + k) ? 32'd1 : 32'd0);
`endif
    end

    // Randomized traffic including mid-stream dly changes.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0,99) == 0, $urandom_range(0,39) == 0, $urandom_range(0,9) < 7,
           3'($urandom_range(0,7)), $urandom, 4'($urandom));

    @(posedge clk);
    #2;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/skew_buffer.md
# skew_buffer

Multi-lane, parametrised delay buffer that generalises the team's fixed 8-deep, 64-bit delay FIFO. Each of LANES channels delays its data by a runtime-selectable base depth plus a fixed per-lane skew (lane k gets k*SKEW extra stages). It sits between the CCI-P MMIO/DMA input path and the systolic MAC array, producing the diagonal operand wavefront the array needs. Adds a synchronous flush, per-lane valid tracking, and a primed status flag.

## Interface
- LANES, 8, number of independent channels
- BITS, 8, data width per lane
- DEPTH, 8, maximum base delay in enable events (≥1)
- SKEW, 1, extra stages per lane index (≥0)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high; priority over every other input
- clr  in  1  synchronous flush; priority over en
- en  in  1  advance all lanes by one stage
- dly  in  $clog2(DEPTH+1)  runtime base delay D
- d  in  LANES*BITS  lane k at bits [k*BITS +: BITS]
- vld_in  in  LANES  per-lane valid sideband
- q  out  LANES*BITS  delayed data, registered
- vld_out  out  LANES  delayed valid, registered
- primed  out  1  all lanes hold only post-reset/flush data

## Operation
- Effective base delay De = 1 if dly==0; DEPTH if dly>DEPTH; else dly.
- Lane latency L_k = De + k*SKEW; storage per lane = DEPTH + k*SKEW entries (line + output register).
- On en: every lane shifts one stage. After en event n, q_k = d_k sampled at event n-L_k+1 (L_k=1: q_k equals d_k of the same event). vld_out tracks vld_in identically.
- en low: all storage, q, vld_out, counter hold.
- dly change mid-stream: storage not cleared; the tap moves. The next en event uses the new De, so q may repeat or skip history. Data not corrupted.
- clr (without rst): zero all storage, q, vld_out; fill counter to 0; primed to 0. en in the same cycle is ignored.
- Fill counter: increments on en, saturates at DEPTH+(LANES-1)*SKEW. primed = (count ≥ L_{LANES-1}) and is registered from the updated count. Lowering dly can raise primed on the next edge; raising dly can drop it.

## Timing
- Reset values: q=0, vld_out=0, primed=0, all storage 0, counter 0.
- Output latency = L_k en events; en-to-output = 1 clk edge.
- No combinational path from any input to any output.
- Simultaneous rst/clr/en: rst > clr > en.

## Configuration
- SKEW_BUFFER_VLD_EN defined: the valid sideband is stored and delayed per lane as above.
- Undefined: no valid storage; vld_in is ignored. vld_out[k] is registered (count ≥ L_k), i.e. lane k has filled since the last reset/clr.

## Test plan
All tests use LANES=4, BITS=8, DEPTH=4, SKEW=1.
- Reset: drive random inputs with rst=1 for 3 cycles -> q=0, vld_out=0, primed=0 on every cycle.
- Skew wavefront: dly=1; en=1 every cycle; d_k=n at event n -> after event 5: q0=5, q1=4, q2=3, q3=2. primed rises after event 4.
- Enable gaps: as above, with en=0 for 3 cycles after event 5 -> q and primed hold. Event 6 resumes: q0=6, q3=3.
- Clamp: dly=7 -> q0 lags d0 by 4 events. dly=0 -> same as dly=1. primed at count 7 and 4 respectively.
- Flush: after priming, assert clr together with en and d=0xAA -> next cycle q=0, vld_out=0, primed=0, counter 0. 0xAA is not captured.
- Valid (SKEW_BUFFER_VLD_EN): dly=2; single vld_in=4'b1111 pulse at event 1 -> vld_out[k] high exactly after event 2+k for one event only.
